// File: rtl/mc_pkg.sv
// Shared definitions for the Monte Carlo payoff path: option encodings,
// scheduler state encoding and default datapath widths.
package mc_pkg;

   localparam logic [1:0] OPT_CALL = 2'b00;
   localparam logic [1:0] OPT_PUT  = 2'b01;

   localparam int unsigned DEF_N_REQ     = 4;
   localparam int unsigned DEF_WIDTH     = 32;
   localparam int unsigned DEF_ACC_WIDTH = 48;
   localparam int unsigned DEF_CNT_WIDTH = 24;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_FIN   = 2'd3
   } sched_state_t;

endpackage

// File: rtl/mc_payoff_scheduler_rr_arbiter.sv
// Round-robin arbiter: first requester at or above ptr (with wrap) wins;
// next_ptr moves past the winner only when the grant is consumed.
module rr_arbiter #(
   parameter int unsigned N_REQ = 4,
   localparam int unsigned PTR_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PTR_W-1:0] ptr,
   input  logic             advance,
   output logic [N_REQ-1:0] grant,
   output logic             any_grant,
   output logic [PTR_W-1:0] next_ptr
);

   logic [PTR_W-1:0] idx;

   always_comb begin
      grant     = '0;
      any_grant = 1'b0;
      next_ptr  = ptr;
      idx       = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         idx = PTR_W'((32'(ptr) + i) % N_REQ);
         if (!any_grant && req[idx]) begin
            any_grant  = 1'b1;
            grant[idx] = 1'b1;
            if (advance) begin
               next_ptr = PTR_W'((32'(idx) + 1) % N_REQ);
            end
         end
      end
   end

endmodule

// File: rtl/mc_payoff_scheduler.sv
// Shares one payoff calculator between N_REQ path engines and accumulates a
// saturating payoff sum over a batch of num_paths paths.
module mc_payoff_scheduler
   import mc_pkg::*;
#(
   parameter int unsigned N_REQ     = DEF_N_REQ,
   parameter int unsigned WIDTH     = DEF_WIDTH,
   parameter int unsigned ACC_WIDTH = DEF_ACC_WIDTH,
   parameter int unsigned CNT_WIDTH = DEF_CNT_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [CNT_WIDTH-1:0]   num_paths,
   input  logic [WIDTH-1:0]       strike,
   input  logic [1:0]             option_type,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [N_REQ*WIDTH-1:0] req_st,
   output logic [N_REQ-1:0]       req_ready,
   output logic                   calc_en,
   output logic [WIDTH-1:0]       calc_st,
   output logic [WIDTH-1:0]       calc_k,
   output logic [1:0]             calc_type,
   input  logic [WIDTH-1:0]       calc_payoff,
   output logic [ACC_WIDTH-1:0]   sum_out,
   output logic [CNT_WIDTH-1:0]   paths_done,
   output logic                   busy,
   output logic                   done,
   output logic                   cfg_err,
   output logic                   sat
);

   localparam int unsigned PTR_W = $clog2(N_REQ);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   sched_state_t state_q, state_nxt;

   logic [PTR_W-1:0]     ptr_q, ptr_nxt;
   logic [N_REQ-1:0]     grant;
   logic                 any_grant;
   logic                 issue;
   logic                 start_ok;
   logic [WIDTH-1:0]     st_sel;
   logic [WIDTH-1:0]     st_hold_q;
   logic [WIDTH-1:0]     k_lat_q;
   logic [1:0]           type_lat_q;
   logic [CNT_WIDTH-1:0] num_lat_q;
   logic [CNT_WIDTH-1:0] issued_q;
   logic [CNT_WIDTH-1:0] paths_q;
   logic [ACC_WIDTH-1:0] sum_q;
   logic [ACC_WIDTH:0]   sum_add;
   logic                 pending_q;
   logic                 sat_q;
   logic                 cfg_err_q;

   rr_arbiter #(.N_REQ(N_REQ)) u_arb (
      .req       (req_valid),
      .ptr       (ptr_q),
      .advance   (issue),
      .grant     (grant),
      .any_grant (any_grant),
      .next_ptr  (ptr_nxt)
   );

   always_comb begin
      st_sel = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (grant[i]) begin
            st_sel = req_st[i*WIDTH +: WIDTH];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state_q;
      issue     = 1'b0;
      start_ok  = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               start_ok = 1'b1;
               if (option_type[1] || (num_paths == '0)) begin
                  state_nxt = ST_FIN;
               end else begin
                  state_nxt = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            busy  = 1'b1;
            issue = any_grant && (issued_q < num_lat_q);
            if (issue && ((issued_q + CNT_ONE) == num_lat_q)) begin
               state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            busy = 1'b1;
            if (pending_q && ((paths_q + CNT_ONE) == num_lat_q)) begin
               state_nxt = ST_FIN;
            end
         end
         ST_FIN: begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // One spare carry bit detects overflow of the accumulator.
   assign sum_add = {1'b0, sum_q} + (ACC_WIDTH+1)'(calc_payoff);

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q      <= '0;
         pending_q  <= 1'b0;
         st_hold_q  <= '0;
         k_lat_q    <= '0;
         type_lat_q <= '0;
         num_lat_q  <= '0;
         issued_q   <= '0;
         paths_q    <= '0;
         sum_q      <= '0;
         sat_q      <= 1'b0;
         cfg_err_q  <= 1'b0;
      end else begin
         pending_q <= issue;
         ptr_q     <= ptr_nxt;
         if (issue) begin
            st_hold_q <= st_sel;
            issued_q  <= issued_q + CNT_ONE;
         end
         if (start_ok) begin
            k_lat_q    <= strike;
            type_lat_q <= option_type;
            num_lat_q  <= num_paths;
            issued_q   <= '0;
            paths_q    <= '0;
            sum_q      <= '0;
            sat_q      <= 1'b0;
            cfg_err_q  <= option_type[1];
            ptr_q      <= '0;
         end else if (pending_q) begin
            paths_q <= paths_q + CNT_ONE;
            if (sum_add[ACC_WIDTH]) begin
               sum_q <= '1;
               sat_q <= 1'b1;
            end else begin
               sum_q <= sum_add[ACC_WIDTH-1:0];
            end
         end
      end
   end

   assign req_ready  = issue ? grant : '0;
   assign calc_en    = issue;
   assign calc_st    = issue ? st_sel : st_hold_q;
   assign calc_k     = k_lat_q;
   assign calc_type  = type_lat_q;
   assign sum_out    = sum_q;
   assign paths_done = paths_q;
   assign cfg_err    = cfg_err_q;
   assign sat        = sat_q;

endmodule
